// File: rtl/microtile_vector_driver.sv
// Host-side stimulus/checker for one microtile pin interface.
// Applies a vector to ui_in, waits, samples uo_out, and reports pass/fail.
module microtile_vector_driver #(
  parameter int unsigned SETTLE_CYCLES = 4,
  parameter int unsigned PULSE_CYCLES  = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        vec_valid,
  output logic        vec_ready,
  input  logic [7:0]  vec_stim,
  input  logic [7:0]  vec_expect,
  input  logic [7:0]  vec_mask,
  input  logic        vec_pulse,
  output logic [7:0]  tile_ui_in,
  input  logic [7:0]  tile_uo_out,
  output logic        res_valid,
  input  logic        res_ready,
  output logic        res_pass,
  output logic [7:0]  res_observed,
  output logic [15:0] pass_count,
  output logic [15:0] fail_count,
  input  logic        clear_counts,
  output logic        busy
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_APPLY  = 3'd1;
  localparam logic [2:0] S_PULSE  = 3'd2;
  localparam logic [2:0] S_SETTLE = 3'd3;
  localparam logic [2:0] S_REPORT = 3'd4;

  localparam logic [7:0] W_SET = 8'(SETTLE_CYCLES);
  localparam logic [7:0] W_PLS = 8'(PULSE_CYCLES - 1);
  localparam logic [15:0] W_MAX = 16'hFFFF;

  logic [2:0]  r_state;
  logic [7:0]  r_cnt;
  logic [7:0]  r_stim;
  logic [7:0]  r_expect;
  logic [7:0]  r_mask;
  logic        r_pulse;
  logic [7:0]  r_ui;
  logic [7:0]  r_sync1;
  logic [7:0]  r_sync2;
  logic        r_pass;
  logic [7:0]  r_obs;
  logic [15:0] r_pass_cnt;
  logic [15:0] r_fail_cnt;

  logic w_accept;
  logic w_sample;
  logic w_pass;

  assign vec_ready = (r_state == S_IDLE);
  assign busy      = (r_state != S_IDLE);
  assign res_valid = (r_state == S_REPORT);
  assign w_accept  = vec_valid && vec_ready;
  assign w_sample  = (r_state == S_SETTLE) &&
                     (r_cnt == 8'd0);
  assign w_pass    = ((r_sync2 ^ r_expect) &
                      r_mask) == 8'h00;

  assign tile_ui_in   = r_ui;
  assign res_pass     = r_pass;
  assign res_observed = r_obs;
  assign pass_count   = r_pass_cnt;
  assign fail_count   = r_fail_cnt;

  // uo_out is asynchronous to clk
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 8'h00;
      r_sync2 <= 8'h00;
    end else begin
      r_sync1 <= tile_uo_out;
      r_sync2 <= r_sync1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_cnt    <= 8'd0;
      r_stim   <= 8'h00;
      r_expect <= 8'h00;
      r_mask   <= 8'h00;
      r_pulse  <= 1'b0;
      r_ui     <= 8'h00;
      r_pass   <= 1'b0;
      r_obs    <= 8'h00;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_stim   <= vec_stim;
            r_expect <= vec_expect;
            r_mask   <= vec_mask;
            r_pulse  <= vec_pulse;
            r_state  <= S_APPLY;
          end
        end
        S_APPLY: begin
          r_ui <= {r_stim[7:1],
                   r_stim[0] & ~r_pulse};
          if (r_pulse) begin
            r_state <= S_PULSE;
            r_cnt   <= W_PLS;
          end else begin
            r_state <= S_SETTLE;
            r_cnt   <= W_SET;
          end
        end
        S_PULSE: begin
          r_ui[0] <= 1'b1;
          if (r_cnt == 8'd0) begin
            r_state <= S_SETTLE;
            r_cnt   <= W_SET;
          end else begin
            r_cnt <= r_cnt - 8'd1;
          end
        end
        S_SETTLE: begin
          // first settle edge ends the pulse
          if (r_pulse) r_ui[0] <= 1'b0;
          if (r_cnt == 8'd0) begin
            r_state <= S_REPORT;
            r_obs   <= r_sync2;
            r_pass  <= w_pass;
          end else begin
            r_cnt <= r_cnt - 8'd1;
          end
        end
        S_REPORT: begin
          if (res_ready) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pass_cnt <= 16'd0;
      r_fail_cnt <= 16'd0;
    end else if (clear_counts) begin
      r_pass_cnt <= 16'd0;
      r_fail_cnt <= 16'd0;
    end else if (w_sample) begin
      if (w_pass) begin
        if (r_pass_cnt != W_MAX)
          r_pass_cnt <= r_pass_cnt + 16'd1;
      end else begin
        if (r_fail_cnt != W_MAX)
          r_fail_cnt <= r_fail_cnt + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_microtile_vector_driver.sv
// Bench for microtile_vector_driver: vector table,
// random vectors against a reference model, corner sequences.
module tb_microtile_vector_driver;

  localparam int S = 4;
  localparam int P = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        vec_valid;
  logic        vec_ready;
  logic [7:0]  vec_stim;
  logic [7:0]  vec_expect;
  logic [7:0]  vec_mask;
  logic        vec_pulse;
  logic [7:0]  tile_ui_in;
  logic [7:0]  tile_uo_out;
  logic        res_valid;
  logic        res_ready;
  logic        res_pass;
  logic [7:0]  res_observed;
  logic [15:0] pass_count;
  logic [15:0] fail_count;
  logic        clear_counts;
  logic        busy;

  microtile_vector_driver #(
    .SETTLE_CYCLES(S),
    .PULSE_CYCLES(P)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .vec_valid(vec_valid),
    .vec_ready(vec_ready),
    .vec_stim(vec_stim),
    .vec_expect(vec_expect),
    .vec_mask(vec_mask),
    .vec_pulse(vec_pulse),
    .tile_ui_in(tile_ui_in),
    .tile_uo_out(tile_uo_out),
    .res_valid(res_valid),
    .res_ready(res_ready),
    .res_pass(res_pass),
    .res_observed(res_observed),
    .pass_count(pass_count),
    .fail_count(fail_count),
    .clear_counts(clear_counts),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // tile models: 0 echo, 1 xor 0x0F,
  // 2 counter on ui[0] rise, 3 nibble swap ^ 0x5A
  logic [1:0] mode;
  logic [7:0] tcnt = 8'h00;

  always @(posedge tile_ui_in[0])
    tcnt <= tcnt + 8'd1;

  function automatic logic [7:0] f3(
    input logic [7:0] x);
    return {x[3:0], x[7:4]} ^ 8'h5A;
  endfunction

  always_comb begin
    tile_uo_out = tile_ui_in;
    case (mode)
      2'd1: tile_uo_out = tile_ui_in ^ 8'h0F;
      2'd2: tile_uo_out = tcnt;
      2'd3: tile_uo_out = f3(tile_ui_in);
      default: tile_uo_out = tile_ui_in;
    endcase
  end

  int checks = 0;
  int errors = 0;
  int m_pass = 0;
  int m_fail = 0;

  task automatic chk(input string nm,
                     input int act,
                     input int req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h",
               nm, act, req);
    end
  endtask

  function automatic logic ref_pass(
    input logic [7:0] o,
    input logic [7:0] e,
    input logic [7:0] m);
    logic ok;
    ok = 1'b1;
    for (int b = 0; b < 8; b++)
      if (m[b] && (o[b] != e[b])) ok = 1'b0;
    return ok;
  endfunction

  task automatic run_vec(input logic [7:0] s,
                         input logic [7:0] e,
                         input logic [7:0] m,
                         input logic p,
                         input int clr_at,
                         input logic [7:0] x_obs,
                         input logic x_pass);
    int n;
    int hi;
    logic [7:0] ui1;
    n = 0;
    while (!vec_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("vec_ready", int'(vec_ready), 1);
    vec_valid  = 1'b1;
    vec_stim   = s;
    vec_expect = e;
    vec_mask   = m;
    vec_pulse  = p;
    @(negedge clk);
    vec_valid = 1'b0;
    n = 0;
    hi = 0;
    ui1 = 8'h00;
    while (!res_valid && n < 600) begin
      clear_counts = (n == clr_at);
      @(negedge clk);
      n++;
      if (n == 1) ui1 = tile_ui_in;
      if (p && tile_ui_in[0]) hi++;
    end
    clear_counts = 1'b0;
    chk("latency", n, 2 + S + (p ? P : 0));
    chk("ui_after_k1", int'(ui1),
        int'(p ? (s & 8'hFE) : s));
    if (p) chk("pulse_width", hi, P);
    chk("res_observed", int'(res_observed),
        int'(x_obs));
    chk("res_pass", int'(res_pass), int'(x_pass));
    if (clr_at >= 0) begin
      m_pass = 0;
      m_fail = 0;
    end else if (x_pass) begin
      if (m_pass < 65535) m_pass++;
    end else begin
      if (m_fail < 65535) m_fail++;
    end
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    chk("pass_count", int'(pass_count), m_pass);
    chk("fail_count", int'(fail_count), m_fail);
  endtask

  typedef struct {
    logic [1:0] md;
    logic [7:0] s;
    logic [7:0] e;
    logic [7:0] m;
    logic       p;
    int         clr;
    logic [7:0] obs;
    logic       ps;
  } vec_t;

  vec_t tbl[9];

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    logic [7:0] s, e, m, eff, o;
    logic       p;
    int n;

    tbl[0] = '{2'd2, 8'h00, 8'h01, 8'hFF, 1'b1,
               -1, 8'h01, 1'b1};
    tbl[1] = '{2'd2, 8'h10, 8'h02, 8'hFF, 1'b1,
               -1, 8'h02, 1'b1};
    tbl[2] = '{2'd2, 8'h21, 8'h07, 8'hFF, 1'b1,
               -1, 8'h03, 1'b0};
    tbl[3] = '{2'd0, 8'hA5, 8'hA5, 8'hFF, 1'b0,
               -1, 8'hA5, 1'b1};
    tbl[4] = '{2'd1, 8'h30, 8'h30, 8'hF0, 1'b0,
               -1, 8'h3F, 1'b1};
    tbl[5] = '{2'd1, 8'h30, 8'h30, 8'hFF, 1'b0,
               -1, 8'h3F, 1'b0};
    tbl[6] = '{2'd0, 8'h5A, 8'h00, 8'h00, 1'b0,
               -1, 8'h5A, 1'b1};
    tbl[7] = '{2'd0, 8'h0F, 8'h0E, 8'h01, 1'b0,
               -1, 8'h0F, 1'b0};
    tbl[8] = '{2'd0, 8'hC3, 8'hC3, 8'hFF, 1'b0,
               1 + S, 8'hC3, 1'b1};

    mode = 2'd2;
    rst_n = 1'b0;
    vec_valid = 1'b0;
    vec_stim = 8'h00;
    vec_expect = 8'h00;
    vec_mask = 8'h00;
    vec_pulse = 1'b0;
    res_ready = 1'b0;
    clear_counts = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_ui", int'(tile_ui_in), 0);
    chk("rst_res_valid", int'(res_valid), 0);
    chk("rst_res_pass", int'(res_pass), 0);
    chk("rst_res_obs", int'(res_observed), 0);
    chk("rst_pass_cnt", int'(pass_count), 0);
    chk("rst_fail_cnt", int'(fail_count), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_vec_ready", int'(vec_ready), 1);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 9; i++) begin
      mode = tbl[i].md;
      run_vec(tbl[i].s, tbl[i].e, tbl[i].m,
              tbl[i].p, tbl[i].clr,
              tbl[i].obs, tbl[i].ps);
    end

    mode = 2'd3;
    for (int i = 0; i < 30; i++) begin
      s = 8'($urandom);
      p = 1'($urandom);
      eff = p ? (s & 8'hFE) : s;
      o = f3(eff);
      case ($urandom_range(0, 3))
        0: m = 8'h00;
        1: m = 8'hFF;
        default: m = 8'($urandom);
      endcase
      e = $urandom_range(0, 1) ? o :
          (o ^ (8'h01 << $urandom_range(0, 7)));
      run_vec(s, e, m, p, -1, o,
              ref_pass(o, e, m));
    end

    // result backpressure
    mode = 2'd0;
    vec_valid  = 1'b1;
    vec_stim   = 8'h66;
    vec_expect = 8'h66;
    vec_mask   = 8'hFF;
    vec_pulse  = 1'b0;
    @(negedge clk);
    vec_stim = 8'h99;
    n = 0;
    while (!res_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("bp_latency", n, 2 + S);
    for (int i = 0; i < 10; i++) begin
      vec_stim = 8'($urandom);
      @(negedge clk);
      chk("bp_res_valid", int'(res_valid), 1);
      chk("bp_res_obs", int'(res_observed), 8'h66);
      chk("bp_vec_ready", int'(vec_ready), 0);
      chk("bp_ui_hold", int'(tile_ui_in), 8'h66);
    end
    chk("bp_res_pass", int'(res_pass), 1);
    if (m_pass < 65535) m_pass++;
    vec_stim   = 8'h3C;
    vec_expect = 8'h3C;
    res_ready  = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    chk("bp_ready_after", int'(vec_ready), 1);
    chk("bp_valid_after", int'(res_valid), 0);
    @(negedge clk);
    vec_valid = 1'b0;
    chk("bp_accept_next", int'(busy), 1);
    n = 0;
    while (!res_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("bp2_latency", n, 2 + S);
    chk("bp2_obs", int'(res_observed), 8'h3C);
    if (m_pass < 65535) m_pass++;
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    chk("bp_pass_count", int'(pass_count), m_pass);

    // saturation of the fail counter
    force dut.r_fail_cnt = 16'hFFFE;
    @(negedge clk);
    release dut.r_fail_cnt;
    m_fail = 16'hFFFE;
    run_vec(8'h11, 8'h22, 8'hFF, 1'b0, -1,
            8'h11, 1'b0);
    run_vec(8'h44, 8'h45, 8'hFF, 1'b0, -1,
            8'h44, 1'b0);
    chk("sat_fail", int'(fail_count), 16'hFFFF);

    // reset during SETTLE
    vec_valid = 1'b1;
    vec_stim  = 8'h77;
    vec_expect = 8'h77;
    vec_mask  = 8'hFF;
    vec_pulse = 1'b0;
    @(negedge clk);
    vec_valid = 1'b0;
    repeat (4) @(negedge clk);
    chk("mid_busy", int'(busy), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("mr_ui", int'(tile_ui_in), 0);
    chk("mr_res_valid", int'(res_valid), 0);
    chk("mr_res_obs", int'(res_observed), 0);
    chk("mr_pass_cnt", int'(pass_count), 0);
    chk("mr_fail_cnt", int'(fail_count), 0);
    chk("mr_busy", int'(busy), 0);
    chk("mr_vec_ready", int'(vec_ready), 1);
    @(negedge clk);
    rst_n = 1'b1;
    m_pass = 0;
    m_fail = 0;
    @(negedge clk);
    run_vec(8'hB4, 8'hB4, 8'hFF, 1'b0, -1,
            8'hB4, 1'b1);

    $display("CHECKS %0d ERRORS %0d",
             checks, errors);
    $finish;
  end

endmodule
